sm4_key_schedule: RTL and testbench
===================================

Name: sm4_key_schedule

Overview:
- Sequential SM4 key-expansion engine; the clocked, parametrised successor to the single-step round-key calculator.
- Accepts a 128-bit master key (MK) over a valid/ready handshake and computes all 32 round keys, RK_PER_CYCLE per clock.
- Stores the keys in an internal bank and serves them through a registered read port.
- The read port has encrypt (forward) and decrypt (reversed) indexing, so the SM4 round datapath can fetch rk[i] or rk[31-i] without a second expansion.

Parameters:
RK_PER_CYCLE, 1, round keys computed per clock; legal values 1, 2, 4, 8. Any other value is an elaboration error. Expansion takes 32/RK_PER_CYCLE cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  master key presented
key_ready  output  1  block can accept a key (state IDLE or DONE)
mkey  input  128  master key; MK0 = mkey[127:96] ... MK3 = mkey[31:0]
rk_ready  output  1  full round-key bank valid for the last accepted key
rd_en  input  1  read request
rd_dec  input  1  0 = forward index, 1 = reversed index (31-rd_idx)
rd_idx  input  5  round index 0..31
rd_valid  output  1  rd_data valid, one cycle after rd_en
rd_data  output  32  requested round key

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, key_ready=1, rk_ready=0, rd_valid=0, rd_data=0;
  - all 32 bank entries=0, round counter=0, K window=0.
- FK constants: a3b1bac6, 56aa3350, 677d9197, b27022dc.
- CK[i]: byte j = (4i+j)*7 mod 256, MSB byte first (CK0=00070e15, CK31=646b7279).
- Step function, identical to the existing calculator:
  - K4 = K0 ^ T'(K1^K2^K3^CK[n]);
  - T' = per-byte SM4 S-box followed by L'(B) = B ^ (B<<<13) ^ (B<<<23).
- State machine: IDLE -> EXPAND -> DONE.
  - IDLE/DONE: key_ready=1. On key_valid&key_ready:
    - latch K0..K3 = MKi^FKi;
    - counter n=0; rk_ready=0; go EXPAND.
  - EXPAND: key_ready=0.
    - Each cycle, chain RK_PER_CYCLE steps combinationally, using CK[n..n+RK_PER_CYCLE-1].
    - Write results to bank[n..]; slide the window by RK_PER_CYCLE; n += RK_PER_CYCLE.
    - On the cycle writing bank[31], go DONE and set rk_ready=1 at the same edge.
  - DONE: hold the bank. A new handshake restarts expansion (rk_ready drops to 0 on the accepting edge). The bank is overwritten progressively; no clear.
- key_valid during EXPAND is ignored; the key must be held until accepted.
- Counter is 6 bits, no wrap. The EXPAND -> DONE transition is at n+RK_PER_CYCLE == 32.
- Read port (any state):
  - rd_en at edge t -> rd_valid=1 and rd_data=bank[rd_dec ? 31-rd_idx : rd_idx] at t+1;
  - rd_en=0 -> rd_valid=0, rd_data holds its last value.
  - Reads while rk_ready=0 return current (possibly stale or partial) bank contents; the consumer must gate on rk_ready.
- Simultaneous read and write of the same entry in one cycle returns the pre-write value (registered read of old bank).
- Reset mid-EXPAND: immediate return to IDLE, bank zeroed, rk_ready=0; no partial-completion indication.
- Latency from handshake edge to rk_ready=1: exactly 32/RK_PER_CYCLE cycles (32, 16, 8, 4).
- Critical path: RK_PER_CYCLE chained S-box+L' stages. The default of 1 is the timing-safe setting.

Test Plan:
- Standard vector, RK_PER_CYCLE=1: mkey=0123456789abcdeffedcba9876543210 -> rk_ready rises exactly 32 cycles after the handshake. Forward reads give idx0=f12186f9, idx1=41662b61, idx2=5a6ab19a, idx3=7ba92077, idx31=9124a012.
- Decrypt indexing: same key, rd_dec=1, rd_idx=0 -> 9124a012; rd_idx=31 -> f12186f9. rd_valid pulses one cycle after each rd_en; back-to-back rd_en every cycle returns one value per cycle.
- Parameter sweep RK_PER_CYCLE=2,4,8: same vector -> identical 32-entry bank; rk_ready latency 16/8/4 cycles; key_ready low for exactly that many cycles.
- Handshake: key_valid asserted mid-EXPAND with a different key -> ignored, bank matches the first key. New key in DONE -> rk_ready falls at the accepting edge and the bank is updated to the new key's schedule (all-zero mkey gives a bank matching a software model).
- Reset mid-EXPAND: drop rst_n at cycle 10 -> key_ready=1, rk_ready=0, rd_data=0 immediately. After release, reads of any index return 00000000. A fresh handshake completes normally.
- Read/write collision: read bank[5] on the cycle it is written during a re-expansion -> old-key value returned; the next read returns the new value.

Source files
------------

// File: rtl/sm4_key_schedule.sv
// SM4 key-expansion engine: accepts a 128-bit master key over a valid/ready
// handshake, derives all 32 round keys RK_PER_CYCLE per clock into a bank,
// and serves them through a registered read port with forward or reversed
// (decrypt-order) indexing.
`timescale 1ns/1ps

module sm4_key_schedule #(
  parameter int RK_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] mkey,
  output logic         rk_ready,
  input  logic         rd_en,
  input  logic         rd_dec,
  input  logic [4:0]   rd_idx,
  output logic         rd_valid,
  output logic [31:0]  rd_data
);

  generate
    if (!(RK_PER_CYCLE == 1 || RK_PER_CYCLE == 2 ||
          RK_PER_CYCLE == 4 || RK_PER_CYCLE == 8)) begin : g_bad_rk_per_cycle
      $error("sm4_key_schedule: RK_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [5:0] STEP = 6'(RK_PER_CYCLE);

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK[i]: byte j is (4i+j)*7 mod 256, most significant byte first
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    logic [7:0]  base;
    logic [7:0]  b;
    w    = '0;
    base = {1'b0, i, 2'b00};
    for (int j = 0; j < 4; j++) begin
      b = (base + 8'(j)) * 8'd7;
      w[31-8*j -: 8] = b;
    end
    return w;
  endfunction

  // T': byte-wise S-box substitution followed by the key-schedule linear map
  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  state_t      state;
  logic [5:0]  n;
  logic [31:0] k [4];
  logic [31:0] bank [32];
  logic [31:0] chain [RK_PER_CYCLE+4];

  // Chain RK_PER_CYCLE key steps: chain[s+4] is the round key for index n+s
  always_comb begin
    for (int s = 0; s < RK_PER_CYCLE + 4; s++) begin
      chain[s] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      chain[j] = k[j];
    end
    for (int s = 0; s < RK_PER_CYCLE; s++) begin
      chain[s+4] = chain[s] ^ t_prime(chain[s+1] ^ chain[s+2] ^ chain[s+3] ^
                                      ck_word(n[4:0] + 5'(s)));
    end
  end

  // Control FSM: handshake, window update, bank writes and ready flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_ready  <= 1'b0;
      n         <= '0;
      for (int j = 0; j < 4; j++) begin
        k[j] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_valid && key_ready) begin
            for (int j = 0; j < 4; j++) begin
              k[j] <= mkey[127-32*j -: 32] ^ FK[j];
            end
            n         <= '0;
            rk_ready  <= 1'b0;
            key_ready <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          for (int s = 0; s < RK_PER_CYCLE; s++) begin
            bank[n[4:0] + 5'(s)] <= chain[s+4];
          end
          for (int j = 0; j < 4; j++) begin
            k[j] <= chain[RK_PER_CYCLE+j];
          end
          n <= n + STEP;
          if (n + STEP == 6'd32) begin
            state     <= DONE;
            rk_ready  <= 1'b1;
            key_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          rk_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; reversed index 31-rd_idx is the bitwise inverse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= bank[rd_dec ? ~rd_idx : rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Self-checking bench for sm4_key_schedule: four instances (1, 2, 4 and 8
// round keys per cycle) share stimulus and are compared against a
// behavioural key-schedule model computed directly from the SM4 rules.
`timescale 1ns/1ps

module tb_sm4_key_schedule;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] mkey = '0;
  logic         rd_en = 1'b0;
  logic         rd_dec = 1'b0;
  logic [4:0]   rd_idx = '0;

  logic [3:0]        key_ready;
  logic [3:0]        rk_ready;
  logic [3:0]        rd_valid;
  logic [3:0][31:0]  rd_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_rk [32];

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Free-running clock shared by all instances
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sm4_key_schedule #(.RK_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready[g]),
      .mkey      (mkey),
      .rk_ready  (rk_ready[g]),
      .rd_en     (rd_en),
      .rd_dec    (rd_dec),
      .rd_idx    (rd_idx),
      .rd_valid  (rd_valid[g]),
      .rd_data   (rd_data[g])
    );
  end

  // Software key schedule: K-array of 36 words, rk[i] = K[i+4]
  function automatic void build_model(input logic [127:0] mk);
    logic [31:0] kw [36];
    logic [31:0] fk [4];
    logic [31:0] ck, t, b, l;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) kw[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      t = kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck;
      for (int j = 0; j < 4; j++) b[31-8*j -: 8] = SBOX[t[31-8*j -: 8]];
      l = b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
      kw[i+4] = kw[i] ^ l;
      model_rk[i] = kw[i+4];
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key and hold it until instance 0 accepts it
  task automatic apply_stimulus(input logic [127:0] key);
    int guard;
    guard = 0;
    mkey = key;
    key_valid = 1'b1;
    while (!key_ready[0] && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check_output("handshake_timeout", 32'(key_ready[0]), 32'd1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] mask);
    int guard;
    guard = 0;
    while ((rk_ready & mask) != mask && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check_output("done_timeout", 32'(rk_ready & mask), 32'(mask));
  endtask

  task automatic read_port(input logic dec, input logic [4:0] idx);
    rd_en = 1'b1;
    rd_dec = dec;
    rd_idx = idx;
    tick();
  endtask

  // Back-to-back forward reads of the whole bank, compared to the model
  task automatic check_bank(input int g, input string tag);
    for (int i = 0; i < 32; i++) begin
      read_port(1'b0, 5'(i));
      check_output($sformatf("%s_valid_%0d", tag, i), 32'(rd_valid[g]), 32'd1);
      check_output($sformatf("%s_rk%0d", tag, i), rd_data[g], model_rk[i]);
    end
    rd_en = 1'b0;
  endtask

  // Hard stop in case anything runs away
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat [4];
    int low [4];
    logic [31:0] old_rk5;
    logic [127:0] key_a, key_b;
    logic [4:0] ridx;
    logic rdec;

    // Reset state
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      check_output($sformatf("reset_key_ready_%0d", g), 32'(key_ready[g]), 32'd1);
      check_output($sformatf("reset_rk_ready_%0d", g), 32'(rk_ready[g]), 32'd0);
      check_output($sformatf("reset_rd_valid_%0d", g), 32'(rd_valid[g]), 32'd0);
      check_output($sformatf("reset_rd_data_%0d", g), rd_data[g], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Standard vector on all widths: latency and key_ready low time
    build_model(STD_KEY);
    apply_stimulus(STD_KEY);
    for (int g = 0; g < 4; g++) begin
      lat[g] = 0;
      low[g] = key_ready[g] ? 0 : 1;
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        if (rk_ready[g] && lat[g] == 0) lat[g] = c;
        if (!key_ready[g]) low[g]++;
      end
    end
    for (int g = 0; g < 4; g++) begin
      check_output($sformatf("latency_rk%0d", 1 << g), 32'(lat[g]), 32'(32 >> g));
      check_output($sformatf("key_ready_low_rk%0d", 1 << g), 32'(low[g]), 32'(32 >> g));
    end

    // Published vector values, forward then reversed, back-to-back
    read_port(1'b0, 5'd0);  check_output("std_fwd0", rd_data[0], 32'hf12186f9);
    read_port(1'b0, 5'd1);  check_output("std_fwd1", rd_data[0], 32'h41662b61);
    read_port(1'b0, 5'd2);  check_output("std_fwd2", rd_data[0], 32'h5a6ab19a);
    read_port(1'b0, 5'd3);  check_output("std_fwd3", rd_data[0], 32'h7ba92077);
    read_port(1'b0, 5'd31); check_output("std_fwd31", rd_data[0], 32'h9124a012);
    read_port(1'b1, 5'd0);  check_output("std_dec0", rd_data[0], 32'h9124a012);
    read_port(1'b1, 5'd31); check_output("std_dec31", rd_data[0], 32'hf12186f9);
    check_output("std_b2b_valid", 32'(rd_valid[0]), 32'd1);
    rd_en = 1'b0;
    tick();
    check_output("idle_rd_valid", 32'(rd_valid[0]), 32'd0);
    check_output("idle_rd_hold", rd_data[0], 32'hf12186f9);

    for (int g = 0; g < 4; g++) check_bank(g, $sformatf("std_bank_rk%0d", 1 << g));

    // Random keys on all widths, with random forward/reversed reads
    for (int r = 0; r < 3; r++) begin
      key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_model(key_a);
      apply_stimulus(key_a);
      wait_done(4'hf);
      for (int g = 0; g < 4; g++) check_bank(g, $sformatf("rand%0d_rk%0d", r, 1 << g));
      for (int i = 0; i < 8; i++) begin
        ridx = 5'($urandom_range(0, 31));
        rdec = 1'($urandom_range(0, 1));
        read_port(rdec, ridx);
        for (int g = 0; g < 4; g++)
          check_output($sformatf("rand%0d_dec%0d_idx%0d", r, rdec, ridx), rd_data[g],
                       model_rk[rdec ? 31 - int'(ridx) : int'(ridx)]);
      end
      rd_en = 1'b0;
    end

    // key_valid during EXPAND with another key is ignored
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_b = ~key_a;
    build_model(key_a);
    apply_stimulus(key_a);
    for (int i = 0; i < 5; i++) tick();
    mkey = key_b;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    key_valid = 1'b0;
    wait_done(4'h1);
    check_bank(0, "ignore_mid_expand");

    // New all-zero key in DONE, with a read colliding with the bank[5] write
    old_rk5 = model_rk[5];
    build_model(128'd0);
    mkey = '0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check_output("restart_rk_ready_drop", 32'(rk_ready[0]), 32'd0);
    check_output("restart_key_ready_drop", 32'(key_ready[0]), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    read_port(1'b0, 5'd5);
    check_output("collision_old_value", rd_data[0], old_rk5);
    read_port(1'b0, 5'd5);
    check_output("collision_new_value", rd_data[0], model_rk[5]);
    rd_en = 1'b0;
    wait_done(4'h1);
    check_bank(0, "zero_key_bank");

    // Reset in the middle of an expansion
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    apply_stimulus(key_a);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    check_output("midreset_key_ready", 32'(key_ready[0]), 32'd1);
    check_output("midreset_rk_ready", 32'(rk_ready[0]), 32'd0);
    check_output("midreset_rd_data", rd_data[0], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ridx = 5'($urandom_range(0, 31));
      read_port(1'($urandom_range(0, 1)), ridx);
      for (int g = 0; g < 4; g++) check_output($sformatf("cleared_bank_%0d_%0d", g, i), rd_data[g], 32'd0);
    end
    rd_en = 1'b0;
    build_model(key_a);
    apply_stimulus(key_a);
    wait_done(4'hf);
    for (int g = 0; g < 4; g++) check_bank(g, $sformatf("post_reset_rk%0d", 1 << g));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
